box_blur_3x3: RTL and testbench
===============================

Name: box_blur_3x3

Overview:
- Streaming 3x3 box-blur stage that fills the second pixel-wise filter slot, directly downstream of the brighten stage.
- Consumes the brighten stage's 8-bit grayscale stream (pix_out/valid_out) and produces a blurred 8-bit stream for the VGA RGB mapping.
- Uses two internal line buffers and a valid/ready handshake.
- One pixel out for every pixel in, so the block drops into the existing raster pipeline without changing pixel count.

Parameters:
- IMG_WIDTH, 640, pixels per line; line-buffer depth.
- IMG_HEIGHT, 480, lines per frame.
- DIV_MULT, 57, reciprocal multiplier for divide-by-9 (57/512).
- DIV_SHIFT, 9, right shift applied after the multiply.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- pix_in  input  8  upstream grayscale pixel.
- valid_in  input  1  pix_in valid.
- sof_in  input  1  qualifies pix_in as pixel (0,0) of a frame.
- module_ready  output  1  block can accept pix_in this cycle.
- filter_enable  input  1  1 = blur, 0 = bypass; sampled with each accepted pixel.
- pix_out  output  8  filtered pixel.
- valid_out  output  1  pix_out valid.
- output_ready  input  1  downstream accepts pix_out this cycle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on port "reset", clock port "clk".
- Transfer rules:
  - Accept = valid_in && module_ready.
  - Output handshake completes on valid_out && output_ready.
- Pipeline: 2 register stages, both advancing on advance = output_ready || !valid_out.
  - module_ready = advance (combinational).
  - Stage 1: window/column capture.
  - Stage 2: sum, multiply, shift into the pix_out register.
  - With output_ready held high, a pixel accepted on cycle N appears on valid_out/pix_out on cycle N+2.
- Stall: while valid_out=1 and output_ready=0, pix_out, valid_out and all pipeline/window/counter state hold, and module_ready=0.
- Bubbles: valid flags propagate per stage. A stage holding no valid data does not block advance.
- Position counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) step only on accept:
  - x wraps to 0 with y+1.
  - y wraps to 0 after IMG_HEIGHT-1.
  - Accept with sof_in=1 forces the current pixel to (0,0); counters then continue to (1,0).
- Line buffers: lb1[x] holds row y-1 and lb2[x] holds row y-2. On accept, lb2[x] <= lb1[x] and lb1[x] <= pix_in, read-before-write at the same x.
- Window: 3x3 shift register of columns {lb2[x], lb1[x], pix_in}, shifted on accept. The output for input (x,y) uses rows y-2..y and columns x-2..x, so the result has a fixed one-pixel spatial lag in x and y.
- Arithmetic:
  - sum is 12 bits unsigned (max 2295).
  - prod = sum*DIV_MULT, 18 bits.
  - pix_out = prod >> DIV_SHIFT, saturated to 255.
- Border: if x<2 or y<2 at accept, pix_out = that pix_in unchanged (no garbage from stale buffers).
- Bypass: filter_enable=0 at accept gives pix_out = pix_in, with the same 2-cycle latency and same handshake. The line buffers and window still update, so toggling mid-frame produces correct blur on later pixels.
- Reset values:
  - valid_out=0, pix_out=0.
  - Stage valids=0, x=0, y=0, window registers=0.
  - Line buffer contents are not cleared; the border rule masks them.
- Reset mid-frame discards all in-flight pixels; the next accepted pixel is (0,0) unless sof_in says otherwise.
- Simultaneous input accept and output stall cannot occur, because module_ready=0 during a stall.

Decomposition:
- Shared package (filter_pkg):
  - PIX_W=8.
  - SUM_W=12.
  - PROD_W=18.
  - pixel_t typedef.
  - Blur constants DIV_MULT and DIV_SHIFT.
- One sub-module: line_buffer, a single-port read-before-write RAM of IMG_WIDTH x PIX_W with an enable. It is instantiated twice.

Test Plan:
- Bench config: IMG_WIDTH=16, IMG_HEIGHT=8, output_ready=1.
- Flat frame 100, enable=1 -> every pix_out = 100 (900*57>>9); border pixels also 100; first valid_out exactly 2 cycles after first accept.
- Flat frame 255 -> all outputs 255, no overflow/wrap.
- All-zero frame with a single 255 at (5,3) -> outputs for inputs x=5..7, y=3..5 equal 28; all other outputs 0.
- Flat 100 frame with output_ready toggled pseudo-randomly -> no drop or duplicate, 128 outputs all 100, pix_out stable while stalled, module_ready=0 whenever valid_out && !output_ready.
- sof_in asserted at input index 37 of a stream of a 16x8 ramp frame (pix = x*16) -> pixel 37 treated as (0,0); rows y<2 and cols x<2 after it pass through unchanged.
- enable=0 ramp frame -> pix_out == pix_in, latency 2. Reset asserted mid-frame with 2 pixels in flight -> valid_out=0 next cycle, the in-flight pixels never appear.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared widths, pixel type and divide-by-9 constants for the pixel-wise filter stages.
package filter_pkg;

  localparam int PIX_W     = 8;
  localparam int SUM_W     = 12;
  localparam int PROD_W    = 18;
  localparam int DIV_MULT  = 57;
  localparam int DIV_SHIFT = 9;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic pixel_t sat_pix(input logic [PROD_W-1:0] v);
    return (v > PROD_W'(255)) ? pixel_t'(8'hFF) : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: combinational read, write on enable, so a read and a
// write at the same address in one cycle returns the old contents.
module line_buffer
  import filter_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);

  pixel_t r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_en) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/box_blur_3x3.sv
// Streaming 3x3 box blur with two line buffers, a two-stage pipeline and
// valid/ready flow control; border pixels and bypass pass the input through.
module box_blur_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DIV_MULT   = filter_pkg::DIV_MULT,
  parameter int DIV_SHIFT  = filter_pkg::DIV_SHIFT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [filter_pkg::PIX_W-1:0] pix_in,
  input  logic                         valid_in,
  input  logic                         sof_in,
  output logic                         module_ready,
  input  logic                         filter_enable,
  output logic [filter_pkg::PIX_W-1:0] pix_out,
  output logic                         valid_out,
  input  logic                         output_ready
);
  import filter_pkg::*;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic              w_advance;
  logic              w_accept;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [XW-1:0]     w_cur_x;
  logic [YW-1:0]     w_cur_y;
  pixel_t            w_lb1_rd;
  pixel_t            w_lb2_rd;
  pixel_t            r_win [3][3];
  logic              r_s1_valid;
  logic              r_s1_pass;
  pixel_t            r_s1_pix;
  logic [SUM_W-1:0]  w_sum;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_quot;
  pixel_t            r_pix_out;
  logic              r_valid_out;

  assign w_advance    = output_ready || !r_valid_out;
  assign w_accept     = valid_in && w_advance;
  assign module_ready = w_advance;
  assign pix_out      = r_pix_out;
  assign valid_out    = r_valid_out;

  // sof_in relocates the pixel being accepted to (0,0)
  assign w_cur_x = sof_in ? '0 : r_x;
  assign w_cur_y = sof_in ? '0 : r_y;

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (w_cur_x),
    .i_wdata (pix_in),
    .o_rdata (w_lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (w_cur_x),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb2_rd)
  );

  // r_win[col][row]: col 2 is the newest column, row 2 is the current line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pass  <= 1'b0;
      r_s1_pix   <= '0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          r_win[c][r] <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_win[0]    <= r_win[1];
        r_win[1]    <= r_win[2];
        r_win[2][0] <= w_lb2_rd;
        r_win[2][1] <= w_lb1_rd;
        r_win[2][2] <= pix_in;
        r_s1_pix    <= pix_in;
        r_s1_pass   <= !filter_enable || (w_cur_x < XW'(2)) || (w_cur_y < YW'(2));
        if (w_cur_x == XW'(IMG_WIDTH - 1)) begin
          r_x <= '0;
          r_y <= (w_cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : w_cur_y + YW'(1);
        end else begin
          r_x <= w_cur_x + XW'(1);
          r_y <= w_cur_y;
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        w_sum = w_sum + SUM_W'(r_win[c][r]);
  end

  assign w_prod = PROD_W'(w_sum) * PROD_W'(DIV_MULT);
  assign w_quot = w_prod >> DIV_SHIFT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_out <= 1'b0;
      r_pix_out   <= '0;
    end else if (w_advance) begin
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) r_pix_out <= r_s1_pass ? r_s1_pix : sat_pix(w_quot);
    end
  end

endmodule

// File: tb/tb_box_blur_3x3.sv
// Self-checking bench for box_blur_3x3: flat-frame vector table, 2D frame reference
// model feeding an expected-output queue, plus stall, sof and reset sequences.
module tb_box_blur_3x3;
  localparam int W = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pix_in = '0;
  logic       valid_in = 1'b0;
  logic       sof_in = 1'b0;
  logic       filter_enable = 1'b1;
  logic       output_ready = 1'b1;
  logic       module_ready;
  logic [7:0] pix_out;
  logic       valid_out;

  box_blur_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix_in),
    .valid_in      (valid_in),
    .sof_in        (sof_in),
    .module_ready  (module_ready),
    .filter_enable (filter_enable),
    .pix_out       (pix_out),
    .valid_out     (valid_out),
    .output_ready  (output_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } sb_t;

  typedef struct {
    logic [7:0] pix;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  sb_t        q[$];
  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         out_cnt = 0;
  int         n28 = 0;
  bit         lat_chk = 0;
  bit         rnd = 0;
  bit         use_tbl = 0;
  logic [7:0] tbl_exp = '0;
  bit         prev_stall = 0;
  logic [7:0] prev_pix = '0;
  logic [7:0] mf [H][W];
  int         mx = 0;
  int         my = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: keep the frame as a 2D image at tracked positions, blur from it.
  function automatic logic [7:0] model(input logic [7:0] p, input logic s, input logic en);
    int         sum;
    logic [7:0] r;
    if (s) begin
      mx = 0;
      my = 0;
    end
    mf[my][mx] = p;
    if (!en || mx < 2 || my < 2) begin
      r = p;
    end else begin
      sum = 0;
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++)
          sum += int'(mf[my-dy][mx-dx]);
      sum = (sum * 57) >> 9;
      r = (sum > 255) ? 8'd255 : sum[7:0];
    end
    mx++;
    if (mx == W) begin
      mx = 0;
      my = (my + 1) % H;
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] p, input logic s, input logic en,
                       input logic ordy, input logic rst, output bit acc);
    sb_t        e;
    logic [7:0] m;
    @(negedge clk);
    valid_in      = v;
    pix_in        = p;
    sof_in        = s;
    filter_enable = en;
    output_ready  = ordy;
    reset         = rst;
    #3;
    if (prev_stall) begin
      check("stall_hold_pix", int'(pix_out), int'(prev_pix));
      check("stall_hold_valid", int'(valid_out), 1);
    end
    if (!rst && valid_out && !output_ready) check("stall_ready_low", int'(module_ready), 0);
    prev_stall = !rst && valid_out && !output_ready;
    prev_pix   = pix_out;
    if (!rst && valid_out && output_ready) begin
      out_cnt++;
      if (pix_out == 8'd28) n28++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pix %0d with none expected (cycle %0d)", pix_out, cycle);
      end else begin
        e = q.pop_front();
        check("pix_out", int'(pix_out), int'(e.exp));
        if (lat_chk) check("latency", cycle - e.cyc, 2);
      end
    end
    acc = v && module_ready && !rst;
    if (acc) begin
      m = model(p, s, en);
      e.exp = use_tbl ? tbl_exp : m;
      e.cyc = cycle;
      q.push_back(e);
    end
    cycle++;
  endtask

  task automatic send(input logic [7:0] p, input logic s, input logic en);
    bit acc = 0;
    for (int t = 0; t < 100 && !acc; t++)
      drive(1'b1, p, s, en, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 300 && q.size() > 0; t++)
      drive(1'b0, 8'd0, 1'b0, 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, acc);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    bit   acc;
    tbl[0] = '{pix: 8'd100, en: 1'b1, exp: 8'd100};
    tbl[1] = '{pix: 8'd255, en: 1'b1, exp: 8'd255};
    tbl[2] = '{pix: 8'd0,   en: 1'b1, exp: 8'd0};
    tbl[3] = '{pix: 8'd9,   en: 1'b1, exp: 8'd9};
    tbl[4] = '{pix: 8'd50,  en: 1'b1, exp: 8'd50};
    tbl[5] = '{pix: 8'd200, en: 1'b0, exp: 8'd200};

    // reset state
    for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_pix_out", int'(pix_out), 0);
    check("reset_module_ready", int'(module_ready), 1);

    // flat frames from the vector table
    lat_chk = 1;
    use_tbl = 1;
    foreach (tbl[k]) begin
      tbl_exp = tbl[k].exp;
      for (int i = 0; i < W * H; i++) send(tbl[k].pix, i == 0, tbl[k].en);
      drain();
    end
    use_tbl = 0;

    // single bright pixel at (5,3)
    n28 = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send((x == 5 && y == 3) ? 8'd255 : 8'd0, x == 0 && y == 0, 1'b1);
    drain();
    check("impulse_count_28", n28, 9);

    // flat 100 with random backpressure
    lat_chk = 0;
    rnd     = 1;
    use_tbl = 1;
    tbl_exp = 8'd100;
    out_cnt = 0;
    for (int i = 0; i < W * H; i++) send(8'd100, i == 0, 1'b1);
    drain();
    check("stall_out_count", out_cnt, W * H);
    rnd     = 0;
    use_tbl = 0;
    lat_chk = 1;

    // ramp stream with sof in the middle
    for (int i = 0; i < W * H; i++) send(8'((i % 16) * 16), i == 37, 1'b1);
    drain();

    // bypass ramp frame
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(8'(x * 16 + y), x == 0 && y == 0, 1'b0);
    drain();

    // reset with two pixels in flight
    send(8'd10, 1'b1, 1'b1);
    send(8'd20, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    q.delete();
    mx = 0;
    my = 0;
    prev_stall = 0;
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    check("mid_reset_valid_out", int'(valid_out), 0);
    check("mid_reset_pix_out", int'(pix_out), 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < W * H; i++) send(8'((i * 37) % 256), 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
